failval_rd_arbiter: RTL and testbench

Two-requester arbiter that shares one failVal ROM read port (valid/ready address channel, valid/ready data channel) between two cascade-stage consumers. It grants address requests round-robin, records the requester ID of every accepted address in an in-order tag FIFO, and steers each returned ROM word back to the requester that issued it. It sits between the stage-evaluation units and the failVal read wrapper, adding no latency on either channel.

---
 rtl/failval_rd_arbiter.sv | 113 +++++++++++
 tb/tb_failval_rd_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/failval_rd_arbiter.sv
// Round-robin arbiter sharing one failVal ROM read port between two requesters.
// An in-order tag FIFO steers each returned ROM word back to the requester that issued its address.
module failval_rd_arbiter #(
  parameter int W_DATA = 13,
  parameter int W_ADDR = 12,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_addr_valid,
  output logic                       req0_addr_ready,
  input  logic [W_ADDR-1:0]          req0_addr_data,
  input  logic                       req1_addr_valid,
  output logic                       req1_addr_ready,
  input  logic [W_ADDR-1:0]          req1_addr_data,
  output logic                       req0_data_valid,
  input  logic                       req0_data_ready,
  output logic signed [W_DATA-1:0]   req0_data,
  output logic                       req1_data_valid,
  input  logic                       req1_data_ready,
  output logic signed [W_DATA-1:0]   req1_data,
  output logic                       mem_addr_valid,
  input  logic                       mem_addr_ready,
  output logic [W_ADDR-1:0]          mem_addr_data,
  input  logic                       mem_data_valid,
  output logic                       mem_data_ready,
  input  logic signed [W_DATA-1:0]   mem_data,
  output logic [$clog2(DEPTH+1)-1:0] outstanding
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] tags;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             last_grant;
  logic             lock;
  logic             lock_id;

  logic winner;
  logic winner_valid;
  logic not_full;
  logic not_empty;
  logic head;
  logic push;
  logic pop;

  // A stalled address keeps its grant until the ROM port takes it, so the address never changes under it.
  always_comb begin
    winner = 1'b0;
    if (lock) begin
      winner = lock_id;
    end else if (req0_addr_valid && req1_addr_valid) begin
      winner = ~last_grant;
    end else if (req1_addr_valid) begin
      winner = 1'b1;
    end
  end

  assign winner_valid    = winner ? req1_addr_valid : req0_addr_valid;
  assign not_full        = (count != CW'(DEPTH));
  assign not_empty       = (count != '0);
  assign head            = tags[rd_ptr];

  assign mem_addr_valid  = winner_valid && not_full;
  assign mem_addr_data   = winner ? req1_addr_data : req0_addr_data;
  assign req0_addr_ready = !winner && mem_addr_ready && not_full;
  assign req1_addr_ready = winner && mem_addr_ready && not_full;

  assign req0_data_valid = mem_data_valid && not_empty && !head;
  assign req1_data_valid = mem_data_valid && not_empty && head;
  assign req0_data       = mem_data;
  assign req1_data       = mem_data;
  assign mem_data_ready  = not_empty && (head ? req1_data_ready : req0_data_ready);

  assign push            = mem_addr_valid && mem_addr_ready;
  assign pop             = mem_data_valid && mem_data_ready;
  assign outstanding     = count;

  // Full is judged on the registered count, so a pop never frees a slot for a push in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tags       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= 1'b1;
      lock       <= 1'b0;
      lock_id    <= 1'b0;
    end else begin
      if (push) begin
        tags[wr_ptr] <= winner;
        wr_ptr       <= wr_ptr + PW'(1);
        last_grant   <= winner;
        lock         <= 1'b0;
      end else if (mem_addr_valid && !mem_addr_ready) begin
        lock    <= 1'b1;
        lock_id <= winner;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_failval_rd_arbiter.sv
// Directed bench for failval_rd_arbiter: a queue-based model checks every output each cycle,
// and literal expectations pin the scenarios from the read-arbiter test plan.
module tb_failval_rd_arbiter;

  localparam int WD  = 13;
  localparam int WA  = 12;
  localparam int DEP = 4;
  localparam int CW  = $clog2(DEP + 1);

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  req0_addr_valid = 1'b0;
  logic                  req0_addr_ready;
  logic [WA-1:0]         req0_addr_data = '0;
  logic                  req1_addr_valid = 1'b0;
  logic                  req1_addr_ready;
  logic [WA-1:0]         req1_addr_data = '0;
  logic                  req0_data_valid;
  logic                  req0_data_ready = 1'b0;
  logic signed [WD-1:0]  req0_data;
  logic                  req1_data_valid;
  logic                  req1_data_ready = 1'b0;
  logic signed [WD-1:0]  req1_data;
  logic                  mem_addr_valid;
  logic                  mem_addr_ready = 1'b0;
  logic [WA-1:0]         mem_addr_data;
  logic                  mem_data_valid = 1'b0;
  logic                  mem_data_ready;
  logic signed [WD-1:0]  mem_data = '0;
  logic [CW-1:0]         outstanding;

  int passed = 0;
  int total  = 0;
  bit cmp_en = 1'b0;

  // Model state: the in-flight requester IDs in issue order, plus the grant history.
  bit mq[$];
  bit m_last = 1'b1;
  bit m_lock = 1'b0;
  bit m_lid  = 1'b0;

  failval_rd_arbiter #(.W_DATA(WD), .W_ADDR(WA), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst),
    .req0_addr_valid(req0_addr_valid), .req0_addr_ready(req0_addr_ready), .req0_addr_data(req0_addr_data),
    .req1_addr_valid(req1_addr_valid), .req1_addr_ready(req1_addr_ready), .req1_addr_data(req1_addr_data),
    .req0_data_valid(req0_data_valid), .req0_data_ready(req0_data_ready), .req0_data(req0_data),
    .req1_data_valid(req1_data_valid), .req1_data_ready(req1_data_ready), .req1_data(req1_data),
    .mem_addr_valid(mem_addr_valid), .mem_addr_ready(mem_addr_ready), .mem_addr_data(mem_addr_data),
    .mem_data_valid(mem_data_valid), .mem_data_ready(mem_data_ready), .mem_data(mem_data),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int got, input int exp);
    total = total + 1;
    if (got == exp) passed = passed + 1;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // One cycle: inputs change just after the rising edge, then settle before literal checks.
  task automatic applyStimulus(input bit v0, input int a0, input bit v1, input int a1, input bit mar,
                               input bit mdv, input int md, input bit r0dr, input bit r1dr);
    @(posedge clk);
    #1;
    req0_addr_valid = v0;  req0_addr_data = WA'(a0);
    req1_addr_valid = v1;  req1_addr_data = WA'(a1);
    mem_addr_ready  = mar;
    mem_data_valid  = mdv; mem_data = WD'(md);
    req0_data_ready = r0dr; req1_data_ready = r1dr;
    #2;
  endtask

  task automatic doReset();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
  endtask

  function automatic bit model_winner();
    if (m_lock) return m_lid;
    if (req0_addr_valid && req1_addr_valid) return !m_last;
    return req1_addr_valid;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_last = 1'b1;
      m_lock = 1'b0;
      m_lid  = 1'b0;
    end else begin
      bit w, mav, push, pop;
      w    = model_winner();
      mav  = (w ? req1_addr_valid : req0_addr_valid) && (mq.size() < DEP);
      push = mav && mem_addr_ready;
      pop  = (mq.size() > 0) && mem_data_valid && (mq[0] ? req1_data_ready : req0_data_ready);
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(w);
        m_last = w;
        m_lock = 1'b0;
      end else if (mav) begin
        m_lock = 1'b1;
        m_lid  = w;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      bit w, has, hd, room;
      w    = model_winner();
      has  = mq.size() > 0;
      hd   = has ? mq[0] : 1'b0;
      room = mq.size() < DEP;
      checkOutput("mem_addr_valid", int'(mem_addr_valid), int'((w ? req1_addr_valid : req0_addr_valid) && room));
      checkOutput("mem_addr_data", int'(mem_addr_data), int'(w ? req1_addr_data : req0_addr_data));
      checkOutput("req0_addr_ready", int'(req0_addr_ready), int'(!w && mem_addr_ready && room));
      checkOutput("req1_addr_ready", int'(req1_addr_ready), int'(w && mem_addr_ready && room));
      checkOutput("req0_data_valid", int'(req0_data_valid), int'(mem_data_valid && has && !hd));
      checkOutput("req1_data_valid", int'(req1_data_valid), int'(mem_data_valid && has && hd));
      checkOutput("mem_data_ready", int'(mem_data_ready), int'(has && (hd ? req1_data_ready : req0_data_ready)));
      checkOutput("req0_data", int'(req0_data), int'(mem_data));
      checkOutput("req1_data", int'(req1_data), int'(mem_data));
      checkOutput("outstanding", int'(outstanding), mq.size());
    end
  end

  initial begin
    // Reset with all inputs low
    @(posedge clk);
    #3 cmp_en = 1'b1;
    checkOutput("rst_outstanding", int'(outstanding), 0);
    checkOutput("rst_mem_addr_valid", int'(mem_addr_valid), 0);
    checkOutput("rst_req0_addr_ready", int'(req0_addr_ready), 0);
    checkOutput("rst_mem_data_ready", int'(mem_data_ready), 0);
    checkOutput("rst_req0_data_valid", int'(req0_data_valid), 0);
    @(posedge clk);
    #3 rst = 1'b1;

    // Single requester: addrs 5,6,7 with words 10,-3,42 one cycle later
    applyStimulus(1, 5, 0, 0, 1, 0, 0, 1, 1);
    checkOutput("s_mad", int'(mem_addr_data), 5);
    checkOutput("s_r0_ready", int'(req0_addr_ready), 1);
    applyStimulus(1, 6, 0, 0, 1, 1, 10, 1, 1);
    checkOutput("s_d0v_a", int'(req0_data_valid), 1);
    checkOutput("s_data_a", int'(req0_data), 10);
    checkOutput("s_out_a", int'(outstanding), 1);
    applyStimulus(1, 7, 0, 0, 1, 1, -3, 1, 1);
    checkOutput("s_data_b", int'(req0_data), -3);
    checkOutput("s_d1v_b", int'(req1_data_valid), 0);
    checkOutput("s_out_b", int'(outstanding), 1);
    applyStimulus(0, 0, 0, 0, 1, 1, 42, 1, 1);
    checkOutput("s_data_c", int'(req0_data), 42);
    checkOutput("s_out_c", int'(outstanding), 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 1);
    checkOutput("s_out_d", int'(outstanding), 0);

    // Contention from reset: ROM sees 0x10,0x20,0x11,0x21
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    doReset();
    applyStimulus(1, 'h10, 1, 'h20, 1, 0, 0, 1, 1);
    checkOutput("c_mad0", int'(mem_addr_data), 'h10);
    checkOutput("c_r1_ready0", int'(req1_addr_ready), 0);
    applyStimulus(1, 'h11, 1, 'h20, 1, 0, 0, 1, 1);
    checkOutput("c_mad1", int'(mem_addr_data), 'h20);
    applyStimulus(1, 'h11, 1, 'h21, 1, 0, 0, 1, 1);
    checkOutput("c_mad2", int'(mem_addr_data), 'h11);
    applyStimulus(0, 0, 1, 'h21, 1, 0, 0, 1, 1);
    checkOutput("c_mad3", int'(mem_addr_data), 'h21);
    applyStimulus(0, 0, 0, 0, 1, 1, 100, 1, 1);
    checkOutput("c_out_full", int'(outstanding), 4);
    checkOutput("c_route0", int'(req0_data_valid), 1);
    applyStimulus(0, 0, 0, 0, 1, 1, 200, 1, 1);
    checkOutput("c_route1", int'(req1_data_valid), 1);
    checkOutput("c_route1_n", int'(req0_data_valid), 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 101, 1, 1);
    checkOutput("c_route2", int'(req0_data_valid), 1);
    applyStimulus(0, 0, 0, 0, 1, 1, 201, 1, 1);
    checkOutput("c_route3", int'(req1_data_valid), 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 1);

    // Lock: req1 stalled 3 cycles keeps its grant even after req0 raises valid
    applyStimulus(0, 0, 1, 'h40, 0, 0, 0, 1, 1);
    checkOutput("l_mad0", int'(mem_addr_data), 'h40);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 'h30, 1, 'h40, 0, 0, 0, 1, 1);
      checkOutput("l_mad_held", int'(mem_addr_data), 'h40);
      checkOutput("l_mav_held", int'(mem_addr_valid), 1);
    end
    applyStimulus(1, 'h30, 1, 'h40, 1, 0, 0, 1, 1);
    checkOutput("l_r1_ready", int'(req1_addr_ready), 1);
    checkOutput("l_r0_ready", int'(req0_addr_ready), 0);
    applyStimulus(1, 'h30, 0, 0, 1, 0, 0, 1, 1);
    checkOutput("l_mad_after", int'(mem_addr_data), 'h30);
    checkOutput("l_r0_ready_after", int'(req0_addr_ready), 1);
    applyStimulus(0, 0, 0, 0, 1, 1, 7, 1, 1);
    checkOutput("l_route1", int'(req1_data_valid), 1);
    applyStimulus(0, 0, 0, 0, 1, 1, 8, 1, 1);
    checkOutput("l_route0", int'(req0_data_valid), 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 1);

    // Full: four accepted, fifth waits until the cycle after a word is returned
    for (int k = 1; k <= 4; k++) applyStimulus(1, k, 0, 0, 1, 0, 0, 1, 1);
    checkOutput("f_out3", int'(outstanding), 3);
    applyStimulus(1, 5, 0, 0, 1, 0, 0, 1, 1);
    checkOutput("f_out4", int'(outstanding), 4);
    checkOutput("f_mav_full", int'(mem_addr_valid), 0);
    checkOutput("f_r0_ready_full", int'(req0_addr_ready), 0);
    applyStimulus(1, 5, 0, 0, 1, 1, 11, 1, 1);
    checkOutput("f_mav_pop_cycle", int'(mem_addr_valid), 0);
    checkOutput("f_mdr_pop_cycle", int'(mem_data_ready), 1);
    applyStimulus(1, 5, 0, 0, 1, 0, 0, 1, 1);
    checkOutput("f_mav_next", int'(mem_addr_valid), 1);
    checkOutput("f_out_next", int'(outstanding), 3);
    for (int k = 12; k <= 15; k++) applyStimulus(0, 0, 0, 0, 1, 1, k, 1, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 1);
    checkOutput("f_drained", int'(outstanding), 0);

    // Response backpressure: head is req1, which holds ready low for 2 cycles
    applyStimulus(0, 0, 1, 'h50, 1, 0, 0, 1, 1);
    applyStimulus(1, 'h51, 0, 0, 1, 0, 0, 1, 1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 1, -7, 1, 0);
      checkOutput("b_mdr_stall", int'(mem_data_ready), 0);
      checkOutput("b_d0v_stall", int'(req0_data_valid), 0);
      checkOutput("b_out_stall", int'(outstanding), 2);
    end
    applyStimulus(0, 0, 0, 0, 1, 1, -7, 1, 1);
    checkOutput("b_mdr_go", int'(mem_data_ready), 1);
    checkOutput("b_d1_data", int'(req1_data), -7);
    applyStimulus(0, 0, 0, 0, 1, 1, 9, 1, 1);
    checkOutput("b_d0v_next", int'(req0_data_valid), 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 1);

    // Reset mid-operation with three outstanding reads
    for (int k = 0; k < 3; k++) applyStimulus(1, 'h60 + k, 0, 0, 1, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 1, 1, 5, 0, 0);
    checkOutput("m_out3", int'(outstanding), 3);
    checkOutput("m_d0v_pre", int'(req0_data_valid), 1);
    #1 rst = 1'b0;
    #1;
    checkOutput("m_out_rst", int'(outstanding), 0);
    checkOutput("m_d0v_rst", int'(req0_data_valid), 0);
    checkOutput("m_d1v_rst", int'(req1_data_valid), 0);
    checkOutput("m_mdr_rst", int'(mem_data_ready), 0);
    mem_data_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    applyStimulus(1, 'h70, 1, 'h71, 1, 0, 0, 1, 1);
    checkOutput("m_tie_mad", int'(mem_addr_data), 'h70);
    checkOutput("m_tie_r0", int'(req0_addr_ready), 1);
    applyStimulus(0, 0, 0, 0, 1, 1, 3, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("m_final_out", int'(outstanding), 0);

    @(posedge clk);
    #3 cmp_en = 1'b0;
    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
